cmd_arbiter: RTL and testbench
==============================

// Module: cmd_arbiter
// PURPOSE
//  Shares one register-write bus between NUM_SRC command sources (UART command
//  receivers, local sequencers), each emitting 1-cycle en pulses + addr/data.
//  One holding slot per source; round-robin grant; req/ack handshake to bus.
//  Sits between the command front-ends and the config register file.
// PARAMETERS
//  NUM_SRC   2    number of command sources (2..8)
//  ADDR_W    8    command address width
//  DATA_W    16   command data width
//  TIMEOUT   255  cycles in BUSY without ack before abort (CMD_ARB_TIMEOUT_EN only)
// PORTS
//  i_clk       in   1                 clock
//  rst_n       in   1                 async reset, active-low
//  src_en      in   NUM_SRC           per-source 1-cycle command strobe
//  src_addr    in   NUM_SRC*ADDR_W    source i addr at [i*ADDR_W +: ADDR_W]
//  src_data    in   NUM_SRC*DATA_W    source i data at [i*DATA_W +: DATA_W]
//  src_busy    out  NUM_SRC           slot i occupied (pending or in flight)
//  src_drop    out  NUM_SRC           1-cycle pulse: strobe on full slot, dropped
//  bus_req     out  1                 command valid on bus
//  bus_addr    out  ADDR_W            granted address, stable while bus_req=1
//  bus_data    out  DATA_W            granted data, stable while bus_req=1
//  bus_src     out  $clog2(NUM_SRC)   index of granted source
//  bus_ack     in   1                 target accepted command (sampled while bus_req=1)
//  bus_timeout out  1                 1-cycle pulse: in-flight command aborted
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, slots empty, state IDLE, rr ptr=NUM_SRC-1.
//  Capture: src_en[i]=1 with slot i empty -> addr/data latched, src_busy[i]=1 next cycle.
//  Drop: src_en[i]=1 with slot i full and not freed this cycle -> src_drop[i]=1 next
//   cycle; stored command untouched.
//  Simultaneous free+strobe on same slot: new command captured, no drop.
//  FSM IDLE: if any slot pending, pick first pending index after rr ptr (wrap
//   NUM_SRC-1 -> 0); load bus_addr/data/src, bus_req<=1 -> BUSY. Else stay.
//  FSM BUSY: bus_req held, bus_* stable. bus_ack=1 -> bus_req<=0, slot freed,
//   rr ptr<=bus_src -> IDLE. bus_ack while bus_req=0 ignored.
//  Latency: src_en@t -> slot@t+1 -> bus_req@t+2 (idle arbiter). After ack@t,
//   bus_req low @t+1, next grant bus_req @t+2 (min 1 idle cycle between commands).
//  Pending slots are not cleared by later strobes; each granted exactly once.
//  Fairness: with all sources pending, grants rotate 0,1,..,NUM_SRC-1,0,..
//  bus_addr/data/src hold last values when bus_req=0.
//  src_busy[i] stays 1 from capture until the cycle after its ack/abort.
// CONFIGURATION
//  CMD_ARB_TIMEOUT_EN defined: cycle counter cleared on BUSY entry; bus_ack not seen
//   within TIMEOUT cycles -> bus_req<=0, slot freed, rr ptr advanced,
//   bus_timeout=1 one cycle, -> IDLE. Ack in the same cycle as expiry wins (no pulse).
//  Not defined: BUSY waits indefinitely; no counter; bus_timeout tied 0.
// TESTING
//  1 Reset: rst_n=0 mid-BUSY -> bus_req, src_busy, src_drop, bus_timeout all 0 at once.
//  2 Single: src_en=01, addr=0x12, data=0xBEEF @t -> bus_req@t+2, bus_src=0,
//    addr=0x12, data=0xBEEF; ack 3 cycles later -> bus_req low, src_busy[0]=0.
//  3 Round-robin: both slots loaded, ack every req -> grant order 0,1; reload both
//    after -> order 0,1 again (ptr=1 wraps to 0).
//  4 Drop: slot 1 pending, src_en[1] with addr=0x55 -> src_drop[1]=1 one cycle,
//    later bus_addr for source 1 is original, never 0x55.
//  5 Free+strobe: src_en[0] same cycle as ack of source 0 -> no drop, new cmd granted.
//  6 Timeout (CMD_ARB_TIMEOUT_EN, TIMEOUT=4): never ack -> bus_timeout pulse after 4
//    BUSY cycles, next pending source granted; ack on expiry cycle -> no pulse.

Source files
------------

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter sharing one register-write bus between
// NUM_SRC command sources, with one holding slot per source and a req/ack
// handshake towards the bus.
// Optional: define CMD_ARB_TIMEOUT_EN to abort an in-flight command after
// TIMEOUT cycles in BUSY without bus_ack.
module cmd_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       i_clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_busy,
  output logic [NUM_SRC-1:0]         src_drop,
  output logic                       bus_req,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [DATA_W-1:0]          bus_data,
  output logic [$clog2(NUM_SRC)-1:0] bus_src,
  input  logic                       bus_ack,
  output logic                       bus_timeout
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("cmd_arbiter: NUM_SRC must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [NUM_SRC-1:0] slot_valid;
  logic [ADDR_W-1:0]  slot_addr [NUM_SRC];
  logic [DATA_W-1:0]  slot_data [NUM_SRC];
  logic [NUM_SRC-1:0] slot_free;

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   cand;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_found;
  logic               grant_load;
  logic               cmd_release;

`ifdef CMD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0]   tmo_cnt;
  logic               tmo_expired;
  logic               cmd_abort;

  assign tmo_expired = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`endif

  assign src_busy = slot_valid;

  // First pending slot strictly after rr_ptr, wrapping NUM_SRC-1 -> 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
      if (!grant_found && slot_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: grant from IDLE, release on ack (or abort) from BUSY.
  always_comb begin
    state_next  = state;
    grant_load  = 1'b0;
    cmd_release = 1'b0;
`ifdef CMD_ARB_TIMEOUT_EN
    cmd_abort   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (grant_found) begin
          grant_load = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          cmd_release = 1'b1;
          state_next  = IDLE;
        end
`ifdef CMD_ARB_TIMEOUT_EN
        else if (tmo_expired) begin
          cmd_release = 1'b1;
          cmd_abort   = 1'b1;
          state_next  = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Slot of the in-flight command is freed in the cycle it is released.
  always_comb begin
    slot_free = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (cmd_release && (bus_src == SRC_W'(i))) begin
        slot_free[i] = 1'b1;
      end
    end
  end

  // Holding slots: a strobe on a slot being freed this cycle is captured, not dropped.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      src_drop   <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        src_drop[i] <= src_en[i] && slot_valid[i] && !slot_free[i];
        if (src_en[i] && (!slot_valid[i] || slot_free[i])) begin
          slot_valid[i] <= 1'b1;
          slot_addr[i]  <= src_addr[i*ADDR_W +: ADDR_W];
          slot_data[i]  <= src_data[i*DATA_W +: DATA_W];
        end else if (slot_free[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Bus outputs and round-robin pointer; bus_* hold their last values while idle.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req  <= 1'b0;
      bus_addr <= '0;
      bus_data <= '0;
      bus_src  <= '0;
      rr_ptr   <= SRC_W'(NUM_SRC - 1);
    end else if (grant_load) begin
      bus_req  <= 1'b1;
      bus_addr <= slot_addr[grant_idx];
      bus_data <= slot_data[grant_idx];
      bus_src  <= grant_idx;
    end else if (cmd_release) begin
      bus_req  <= 1'b0;
      rr_ptr   <= bus_src;
    end
  end

`ifdef CMD_ARB_TIMEOUT_EN
  // BUSY cycle counter, cleared on every grant.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (grant_load) begin
      tmo_cnt <= '0;
    end else if (state == BUSY && !tmo_expired) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // One-cycle abort pulse.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= cmd_abort;
    end
  end
`else
  assign bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed self-checking bench for cmd_arbiter (NUM_SRC=2, TIMEOUT=4).
module tb_cmd_arbiter;

  logic        i_clk;
  logic        rst_n;
  logic [1:0]  src_en;
  logic [15:0] src_addr;
  logic [31:0] src_data;
  logic [1:0]  src_busy;
  logic [1:0]  src_drop;
  logic        bus_req;
  logic [7:0]  bus_addr;
  logic [15:0] bus_data;
  logic [0:0]  bus_src;
  logic        bus_ack;
  logic        bus_timeout;

  int checks = 0;
  int errors = 0;

  cmd_arbiter #(
    .NUM_SRC(2),
    .ADDR_W (8),
    .DATA_W (16),
    .TIMEOUT(4)
  ) dut (
    .i_clk      (i_clk),
    .rst_n      (rst_n),
    .src_en     (src_en),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .src_busy   (src_busy),
    .src_drop   (src_drop),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_src    (bus_src),
    .bus_ack    (bus_ack),
    .bus_timeout(bus_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    src_en   = en;
    src_addr = {a1, a0};
    src_data = {d1, d0};
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    src_en  = '0;
    bus_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; src_en = '0; src_addr = '0; src_data = '0; bus_ack = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus_req); end
    checks++; if (src_busy !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b expected 00", src_busy); end
    checks++; if (src_drop !== 2'b00) begin errors++; $display("FAIL rst_drop: got %b expected 00", src_drop); end
    checks++; if (bus_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", bus_timeout); end
    checks++; if ({bus_addr, bus_data, bus_src} !== 25'h0) begin errors++;
      $display("FAIL rst_bus: got addr %h data %h src %h expected all 0", bus_addr, bus_data, bus_src); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(2'b01, 8'h12, 8'h00, 16'hBEEF, 16'h0000);
    step();
    src_en = '0;
    checks++; if (src_busy !== 2'b01) begin errors++; $display("FAIL single_capture: got busy %b expected 01", src_busy); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL single_req_t1: got %b expected 0", bus_req); end
    step();
    checks++; if ({bus_req, bus_src, bus_addr, bus_data} !== {1'b1, 1'b0, 8'h12, 16'hBEEF}) begin errors++;
      $display("FAIL single_grant: got req %b src %h addr %h data %h expected 1 0 12 beef", bus_req, bus_src, bus_addr, bus_data); end
    step();
    step();
    checks++; if ({bus_req, bus_addr, bus_data} !== {1'b1, 8'h12, 16'hBEEF}) begin errors++;
      $display("FAIL single_hold: got req %b addr %h data %h expected 1 12 beef", bus_req, bus_addr, bus_data); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    checks++; if ({bus_req, src_busy} !== 3'b000) begin errors++;
      $display("FAIL single_ack: got req %b busy %b expected 0 00", bus_req, src_busy); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    checks++; if ({bus_req, bus_addr, bus_data} !== {1'b0, 8'h12, 16'hBEEF}) begin errors++;
      $display("FAIL single_idle_hold: got req %b addr %h data %h expected 0 12 beef", bus_req, bus_addr, bus_data); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      drive(2'b11, 8'h10, 8'h21, 16'h1000, 16'h2111);
      step();
      src_en = '0;
      step();
      checks++; if ({bus_req, bus_src, bus_addr} !== {1'b1, 1'b0, 8'h10}) begin errors++;
        $display("FAIL rr_first_p%0d: got req %b src %h addr %h expected 1 0 10", pass, bus_req, bus_src, bus_addr); end
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checks++; if ({bus_req, src_busy} !== 3'b010) begin errors++;
        $display("FAIL rr_gap_p%0d: got req %b busy %b expected 0 10", pass, bus_req, src_busy); end
      step();
      checks++; if ({bus_req, bus_src, bus_addr, bus_data} !== {1'b1, 1'b1, 8'h21, 16'h2111}) begin errors++;
        $display("FAIL rr_second_p%0d: got req %b src %h addr %h data %h expected 1 1 21 2111", pass, bus_req, bus_src, bus_addr, bus_data); end
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      checks++; if ({bus_req, src_busy} !== 3'b000) begin errors++;
        $display("FAIL rr_done_p%0d: got req %b busy %b expected 0 00", pass, bus_req, src_busy); end
    end
  endtask

  task automatic test_drop();
    drive(2'b11, 8'h30, 8'h41, 16'h3030, 16'h4141);
    step();
    src_en = '0;
    step();
    checks++; if ({bus_req, bus_src} !== 2'b10) begin errors++;
      $display("FAIL drop_grant0: got req %b src %h expected 1 0", bus_req, bus_src); end
    drive(2'b10, 8'h30, 8'h55, 16'h3030, 16'h5555);
    step();
    src_en = '0;
    checks++; if ({src_drop, src_busy} !== 4'b1011) begin errors++;
      $display("FAIL drop_pulse: got drop %b busy %b expected 10 11", src_drop, src_busy); end
    step();
    checks++; if (src_drop !== 2'b00) begin errors++; $display("FAIL drop_one_cycle: got %b expected 00", src_drop); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    checks++; if ({bus_req, bus_src, bus_addr, bus_data} !== {1'b1, 1'b1, 8'h41, 16'h4141}) begin errors++;
      $display("FAIL drop_original: got req %b src %h addr %h data %h expected 1 1 41 4141", bus_req, bus_src, bus_addr, bus_data); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
  endtask

  task automatic test_free_strobe();
    drive(2'b01, 8'h60, 8'h00, 16'h6060, 16'h0000);
    step();
    src_en = '0;
    step();
    checks++; if ({bus_req, bus_src, bus_addr} !== {1'b1, 1'b0, 8'h60}) begin errors++;
      $display("FAIL fs_grant: got req %b src %h addr %h expected 1 0 60", bus_req, bus_src, bus_addr); end
    drive(2'b01, 8'h61, 8'h00, 16'h6161, 16'h0000);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    src_en = '0;
    checks++; if ({bus_req, src_drop, src_busy} !== 5'b00001) begin errors++;
      $display("FAIL fs_capture: got req %b drop %b busy %b expected 0 00 01", bus_req, src_drop, src_busy); end
    step();
    checks++; if ({bus_req, bus_src, bus_addr, bus_data} !== {1'b1, 1'b0, 8'h61, 16'h6161}) begin errors++;
      $display("FAIL fs_regrant: got req %b src %h addr %h data %h expected 1 0 61 6161", bus_req, bus_src, bus_addr, bus_data); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
  endtask

`ifdef CMD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    drive(2'b11, 8'h70, 8'h71, 16'h7070, 16'h7171);
    step();
    src_en = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if ({bus_req, bus_timeout} !== 2'b10) begin errors++;
        $display("FAIL tmo_busy_c%0d: got req %b timeout %b expected 1 0", c, bus_req, bus_timeout); end
    end
    step();
    checks++; if ({bus_req, bus_timeout, src_busy} !== 4'b0110) begin errors++;
      $display("FAIL tmo_abort: got req %b timeout %b busy %b expected 0 1 10", bus_req, bus_timeout, src_busy); end
    step();
    checks++; if ({bus_req, bus_timeout, bus_src, bus_addr} !== {1'b1, 1'b0, 1'b1, 8'h71}) begin errors++;
      $display("FAIL tmo_next: got req %b timeout %b src %h addr %h expected 1 0 1 71", bus_req, bus_timeout, bus_src, bus_addr); end
    step();
    step();
    step();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    checks++; if ({bus_req, bus_timeout, src_busy} !== 4'b0000) begin errors++;
      $display("FAIL tmo_ack_wins: got req %b timeout %b busy %b expected 0 0 00", bus_req, bus_timeout, src_busy); end
    step();
    checks++; if (bus_timeout !== 1'b0) begin errors++; $display("FAIL tmo_no_pulse: got %b expected 0", bus_timeout); end
  endtask
`endif

  task automatic test_reset_mid_busy();
    drive(2'b11, 8'h80, 8'h81, 16'h8080, 16'h8181);
    step();
    src_en = '0;
    step();
    drive(2'b01, 8'h88, 8'h81, 16'h8888, 16'h8181);
    step();
    src_en = '0;
    checks++; if ({bus_req, src_drop} !== 3'b101) begin errors++;
      $display("FAIL mid_pre: got req %b drop %b expected 1 01", bus_req, src_drop); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus_req, src_busy, src_drop, bus_timeout} !== 6'b0) begin errors++;
      $display("FAIL mid_reset: got req %b busy %b drop %b timeout %b expected all 0", bus_req, src_busy, src_drop, bus_timeout); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({bus_req, src_busy} !== 3'b000) begin errors++;
      $display("FAIL mid_after: got req %b busy %b expected 0 00", bus_req, src_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_free_strobe();
`ifdef CMD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
